// File: rtl/ps2_pkg.sv
// Shared constants, state type and ps2_key field layout for the PS/2 set-2 key encoder.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_BRK    = 8'hF0;
    localparam logic [7:0] PS2_PAUSE  = 8'hE1;
    localparam logic [7:0] PS2_BAT_OK = 8'hAA;
    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_ECHO   = 8'hEE;
    localparam logic [7:0] PS2_RESEND = 8'hFE;
    localparam logic [7:0] PS2_ERR0   = 8'h00;
    localparam logic [7:0] PS2_ERR1   = 8'hFF;

    localparam logic [7:0] PS2_PAUSE_CODE = 8'h77;
    localparam logic [2:0] PS2_PAUSE_LAST = 3'd6;

    localparam int KEY_TOGGLE  = 10;
    localparam int KEY_PRESSED = 9;
    localparam int KEY_EXT     = 8;
    localparam int KEY_CODE_HI = 7;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PREFIX = 2'd1,
        S_PAUSE  = 2'd2
    } ps2_state_t;

    function automatic logic is_chatter(input logic [7:0] b);
        return (b == PS2_BAT_OK) || (b == PS2_ACK) || (b == PS2_ECHO) ||
               (b == PS2_RESEND) || (b == PS2_ERR0) || (b == PS2_ERR1);
    endfunction

endpackage

// File: rtl/ps2_key_bitmap.sv
// 512x1 "key held" table: asynchronous read, synchronous set/clear write, clear-all on reset.
module ps2_key_bitmap
    import ps2_pkg::*;
(
    input  logic       clk_i,
    input  logic       srst_i,
    input  logic [8:0] addr_i,
    output logic       held_o,
    input  logic       wr_en_i,
    input  logic       wr_set_i
);

    logic [511:0] bits_q;

    assign held_o = bits_q[addr_i];

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            bits_q <= '0;
        end else if (wr_en_i) begin
            bits_q[addr_i] <= wr_set_i;
        end
    end

endmodule

// File: rtl/ps2_key_encoder.sv
// Turns a PS/2 set-2 byte stream into the toggle-style 11-bit ps2_key word.
module ps2_key_encoder
    import ps2_pkg::*;
#(
    parameter int TIMEOUT       = 50000,
    parameter int FILTER_REPEAT = 1
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic [10:0] ps2_key,
    output logic        key_strobe,
    output logic        prefix_pending
);

    localparam int TW = $clog2(TIMEOUT);

    ps2_state_t  state_q, state_d;
    logic        ext_q, ext_d;
    logic        brk_q, brk_d;
    logic [2:0]  pcnt_q, pcnt_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [10:0] key_q, key_d;
    logic        strobe_q, strobe_d;

    logic final_hit;
    logic held;
    logic fire;

    // A byte outside Pause that is neither a prefix nor chatter completes a key code.
    assign final_hit = rx_valid && (state_q != S_PAUSE) &&
                       (rx_data != PS2_EXT) && (rx_data != PS2_BRK) &&
                       (rx_data != PS2_PAUSE) && !is_chatter(rx_data);

    // Makes of an already-held key are swallowed; breaks always go through.
    assign fire = final_hit && (brk_q || !held);

    generate
        if (FILTER_REPEAT == 1) begin : g_filter
            ps2_key_bitmap u_bitmap (
                .clk_i    (clk_sys),
                .srst_i   (reset),
                .addr_i   ({ext_q, rx_data}),
                .held_o   (held),
                .wr_en_i  (fire),
                .wr_set_i (~brk_q)
            );
        end else begin : g_nofilter
            assign held = 1'b0;
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        ext_d    = ext_q;
        brk_d    = brk_q;
        pcnt_d   = pcnt_q;
        tcnt_d   = tcnt_q;
        key_d    = key_q;
        strobe_d = 1'b0;

        if (rx_valid) begin
            tcnt_d = '0;
            if (state_q == S_PAUSE) begin
                if (pcnt_q == PS2_PAUSE_LAST) begin
                    key_d    = {~key_q[KEY_TOGGLE], 1'b1, 1'b1, PS2_PAUSE_CODE};
                    strobe_d = 1'b1;
                    pcnt_d   = '0;
                    state_d  = S_IDLE;
                end else begin
                    pcnt_d = pcnt_q + 3'd1;
                end
            end else if (rx_data == PS2_EXT) begin
                ext_d   = 1'b1;
                state_d = S_PREFIX;
            end else if (rx_data == PS2_BRK) begin
                brk_d   = 1'b1;
                state_d = S_PREFIX;
            end else if (rx_data == PS2_PAUSE) begin
                ext_d   = 1'b0;
                brk_d   = 1'b0;
                pcnt_d  = '0;
                state_d = S_PAUSE;
            end else begin
                if (fire) begin
                    key_d    = {~key_q[KEY_TOGGLE], ~brk_q, ext_q, rx_data};
                    strobe_d = 1'b1;
                end
                ext_d   = 1'b0;
                brk_d   = 1'b0;
                state_d = S_IDLE;
            end
        end else if (state_q != S_IDLE) begin
            // Counter holds TIMEOUT-1 on the TIMEOUT-th idle cycle after the last byte.
            if (tcnt_q == TW'(TIMEOUT - 1)) begin
                ext_d   = 1'b0;
                brk_d   = 1'b0;
                pcnt_d  = '0;
                tcnt_d  = '0;
                state_d = S_IDLE;
            end else begin
                tcnt_d = tcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q  <= S_IDLE;
            ext_q    <= 1'b0;
            brk_q    <= 1'b0;
            pcnt_q   <= '0;
            tcnt_q   <= '0;
            key_q    <= '0;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ext_q    <= ext_d;
            brk_q    <= brk_d;
            pcnt_q   <= pcnt_d;
            tcnt_q   <= tcnt_d;
            key_q    <= key_d;
            strobe_q <= strobe_d;
        end
    end

    assign ps2_key        = key_q;
    assign key_strobe     = strobe_q;
    assign prefix_pending = (state_q != S_IDLE);

endmodule
